// File: rtl/seg_scan_reader_if.sv
// Display-bus bundle for seg_scan_reader: scanned anode/segment lines plus the reconstructed frame.
// Defining SEG_SCAN_DP_EN adds the decimal-point line and its per-digit result.
interface seg_scan_reader_if #(
  parameter int DIGITS = 4
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic [4*DIGITS-1:0] value;
  logic                frame_valid;
  logic                pat_err;
  logic                an_err;
  logic [IDX_W-1:0]    err_idx;
`ifdef SEG_SCAN_DP_EN
  logic                dp;
  logic [DIGITS-1:0]   value_dp;

  modport master (output an, seg, dp, input value, value_dp, frame_valid, pat_err, an_err, err_idx);
  modport slave  (input an, seg, dp, output value, value_dp, frame_valid, pat_err, an_err, err_idx);
`else
  modport master (output an, seg, input value, frame_valid, pat_err, an_err, err_idx);
  modport slave  (input an, seg, output value, frame_valid, pat_err, an_err, err_idx);
`endif
endinterface

// File: rtl/seg_scan_reader.sv
// Reconstructs the hex frame shown on a multiplexed active-low seven-segment bus.
// Optional decimal-point capture is enabled by defining SEG_SCAN_DP_EN.
module seg_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  seg_scan_reader_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef SEG_SCAN_DP_EN
  localparam int SW = DIGITS + 8;
`else
  localparam int SW = DIGITS + 7;
`endif

  logic [SW-1:0]       w_in, r_smp;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic                r_cap, w_cap_next;
  logic                w_match, w_cap;
  logic [DIGITS-1:0]   w_an, w_low;
  logic [6:0]          w_seg;
  logic [4:0]          w_dec;
  logic                w_one, w_multi;
  logic [IDX_W-1:0]    w_idx;
  logic                w_dp_lit;

  logic [4*DIGITS-1:0] r_shadow, w_shadow_next, r_value, w_value_next;
  logic [DIGITS-1:0]   r_shadow_dp, w_shadow_dp_next, r_value_dp, w_value_dp_next;
  logic [DIGITS-1:0]   r_seen, w_seen_next;
  logic                r_fv, r_pe, r_ae, w_fv_next, w_pe_next, w_ae_next;
  logic [IDX_W-1:0]    r_err_idx, w_err_idx_next;

  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'b0000001: f_decode = 5'h10;
      7'b1001111: f_decode = 5'h11;
      7'b0010010: f_decode = 5'h12;
      7'b0000110: f_decode = 5'h13;
      7'b1001100: f_decode = 5'h14;
      7'b0100100: f_decode = 5'h15;
      7'b0100000: f_decode = 5'h16;
      7'b0001111: f_decode = 5'h17;
      7'b0000000: f_decode = 5'h18;
      7'b0001100: f_decode = 5'h19;
      7'b0001000: f_decode = 5'h1A;
      7'b1100000: f_decode = 5'h1B;
      7'b0110001: f_decode = 5'h1C;
      7'b1000010: f_decode = 5'h1D;
      7'b0110000: f_decode = 5'h1E;
      7'b0111000: f_decode = 5'h1F;
      default:    f_decode = 5'h00;
    endcase
  endfunction

`ifdef SEG_SCAN_DP_EN
  assign w_in     = {bus.an, bus.seg, bus.dp};
  assign w_dp_lit = ~r_smp[0];
`else
  assign w_in     = {bus.an, bus.seg};
  assign w_dp_lit = 1'b0;
`endif

  assign w_an    = r_smp[SW-1 -: DIGITS];
  assign w_seg   = r_smp[SW-DIGITS-1 -: 7];
  assign w_low   = ~w_an;
  assign w_match = (w_in == r_smp);
  assign w_dec   = f_decode(w_seg);
  assign w_one   = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
  assign w_multi = (w_low != '0) && !w_one;
  // Fires on the edge that completes STABLE_CYCLES identical samples, once per dwell.
  assign w_cap   = w_match && !r_cap && (r_cnt == CNT_W'(STABLE_CYCLES - 2));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (w_low[i]) w_idx = w_idx | IDX_W'(i);
  end

  always_comb begin
    w_cnt_next       = r_cnt;
    w_cap_next       = r_cap;
    w_shadow_next    = r_shadow;
    w_shadow_dp_next = r_shadow_dp;
    w_seen_next      = r_seen;
    w_value_next     = r_value;
    w_value_dp_next  = r_value_dp;
    w_fv_next        = 1'b0;
    w_pe_next        = 1'b0;
    w_ae_next        = 1'b0;
    w_err_idx_next   = r_err_idx;

    if (!w_match) begin
      w_cnt_next = '0;
      w_cap_next = 1'b0;
    end else begin
      if (r_cnt != CNT_W'(STABLE_CYCLES)) w_cnt_next = r_cnt + 1'b1;
      if (w_cap) w_cap_next = 1'b1;
    end

    // Publish first so a capture on the same edge lands in the fresh mask.
    if (r_seen == '1) begin
      w_value_next    = r_shadow;
      w_value_dp_next = r_shadow_dp;
      w_fv_next       = 1'b1;
      w_seen_next     = '0;
    end

    if (w_cap) begin
      if (w_one) begin
        if (w_dec[4]) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (w_low[i]) begin
              w_shadow_next[4*i +: 4] = w_dec[3:0];
              w_shadow_dp_next[i]     = w_dp_lit;
              w_seen_next[i]          = 1'b1;
            end
          end
        end else begin
          w_pe_next      = 1'b1;
          w_err_idx_next = w_idx;
        end
      end else if (w_multi) begin
        w_ae_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp       <= '1;
      r_cnt       <= '0;
      r_cap       <= 1'b0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_seen      <= '0;
      r_value     <= '0;
      r_value_dp  <= '0;
      r_fv        <= 1'b0;
      r_pe        <= 1'b0;
      r_ae        <= 1'b0;
      r_err_idx   <= '0;
    end else begin
      r_smp       <= w_in;
      r_cnt       <= w_cnt_next;
      r_cap       <= w_cap_next;
      r_shadow    <= w_shadow_next;
      r_shadow_dp <= w_shadow_dp_next;
      r_seen      <= w_seen_next;
      r_value     <= w_value_next;
      r_value_dp  <= w_value_dp_next;
      r_fv        <= w_fv_next;
      r_pe        <= w_pe_next;
      r_ae        <= w_ae_next;
      r_err_idx   <= w_err_idx_next;
    end
  end

  assign bus.value       = r_value;
  assign bus.frame_valid = r_fv;
  assign bus.pat_err     = r_pe;
  assign bus.an_err      = r_ae;
  assign bus.err_idx     = r_err_idx;
`ifdef SEG_SCAN_DP_EN
  assign bus.value_dp    = r_value_dp;
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboard bench for seg_scan_reader: a per-edge dwell model predicts frames and error pulses.
module tb_seg_scan_reader;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  typedef struct { int edge_n; logic [15:0] val; logic [3:0] dp; } frame_t;
  typedef struct { int edge_n; int idx; } perr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_reader_if #(.DIGITS(DIGITS)) u_if ();
  seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [6:0] tbl [16];

  frame_t fq[$];
  perr_t  pq[$];
  int     aq[$];

  logic [11:0] m_prev;
  int          m_run;
  logic [15:0] m_shadow;
  logic [3:0]  m_shadow_dp;
  logic [3:0]  m_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prev      = '1;
    m_run       = 0;
    m_shadow    = '0;
    m_shadow_dp = '0;
    m_seen      = '0;
    fq.delete();
    pq.delete();
    aq.delete();
  endtask

  // Drive one edge's worth of bus and predict what that edge does.
  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic dp);
    logic [11:0] pat;
    int zeros, idx, nib;
    frame_t f;
    perr_t p;
    @(negedge clk);
    u_if.an  = a;
    u_if.seg = s;
`ifdef SEG_SCAN_DP_EN
    u_if.dp = dp;
    pat = {a, s, dp};
`else
    pat = {a, s, 1'b1};
`endif
    if (pat == m_prev) begin
      if (m_run <= STABLE) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = pat;
    if (m_seen == 4'hF) begin
      f.edge_n = cyc + 1;
      f.val    = m_shadow;
      f.dp     = m_shadow_dp;
      fq.push_back(f);
      m_seen = '0;
    end
    if (m_run == STABLE) begin
      zeros = 0;
      idx   = 0;
      for (int i = 0; i < DIGITS; i++)
        if (!a[i]) begin zeros++; idx = i; end
      if (zeros == 1) begin
        nib = -1;
        for (int n = 0; n < 16; n++)
          if (tbl[n] == s) nib = n;
        if (nib >= 0) begin
          m_shadow[4*idx +: 4] = 4'(nib);
          m_shadow_dp[idx]     = ~dp;
          m_seen[idx]          = 1'b1;
        end else begin
          p.edge_n = cyc + 1;
          p.idx    = idx;
          pq.push_back(p);
        end
      end else if (zeros > 1) begin
        aq.push_back(cyc + 1);
      end
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic dp, input int n);
    repeat (n) step(a, s, dp);
  endtask

  task automatic show(input int d, input int nib, input int n, input logic dp = 1'b1);
    logic [3:0] a;
    a    = 4'hF;
    a[d] = 1'b0;
    hold(a, tbl[nib], dp, n);
  endtask

  task automatic idle(input int n);
    hold(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    u_if.an  = '1;
    u_if.seg = '1;
`ifdef SEG_SCAN_DP_EN
    u_if.dp  = 1'b1;
`endif
    model_reset();
    #1;
    check("rst_value", 32'(u_if.value), 32'h0);
    check("rst_frame_valid", 32'(u_if.frame_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT is due to present a pulse.
  initial begin : monitor
    frame_t f;
    perr_t p;
    logic exp_fv, exp_pe, exp_ae;
    logic [15:0] last_val;
    logic [3:0] last_dp;
    int exp_idx;
    last_val = '0;
    last_dp  = '0;
    exp_idx  = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        last_val = '0;
        last_dp  = '0;
        exp_idx  = 0;
      end else begin
        exp_fv = (fq.size() > 0) && (fq[0].edge_n == cyc);
        exp_pe = (pq.size() > 0) && (pq[0].edge_n == cyc);
        exp_ae = (aq.size() > 0) && (aq[0] == cyc);
        check("frame_valid", 32'(u_if.frame_valid), 32'(exp_fv));
        check("pat_err", 32'(u_if.pat_err), 32'(exp_pe));
        check("an_err", 32'(u_if.an_err), 32'(exp_ae));
        if (exp_fv) begin
          f = fq.pop_front();
          last_val = f.val;
          last_dp  = f.dp;
          $display("edge %0d frame value=%h", cyc, u_if.value);
        end
        if (exp_pe) begin
          p = pq.pop_front();
          exp_idx = p.idx;
          $display("edge %0d pat_err err_idx=%0d", cyc, u_if.err_idx);
        end
        if (exp_ae) begin
          void'(aq.pop_front());
          $display("edge %0d an_err", cyc);
        end
        check("value", 32'(u_if.value), 32'(last_val));
        check("err_idx", 32'(u_if.err_idx), 32'(exp_idx));
`ifdef SEG_SCAN_DP_EN
        check("value_dp", 32'(u_if.value_dp), 32'(last_dp));
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int ord[4];
    int j, t;
    tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111; tbl[2]  = 7'b0010010; tbl[3]  = 7'b0000110;
    tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100; tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001111;
    tbl[8]  = 7'b0000000; tbl[9]  = 7'b0001100; tbl[10] = 7'b0001000; tbl[11] = 7'b1100000;
    tbl[12] = 7'b0110001; tbl[13] = 7'b1000010; tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;
    u_if.an  = '1;
    u_if.seg = '1;
`ifdef SEG_SCAN_DP_EN
    u_if.dp  = 1'b1;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_value", 32'(u_if.value), 32'h0);
    check("reset_frame_valid", 32'(u_if.frame_valid), 32'h0);
    check("reset_pat_err", 32'(u_if.pat_err), 32'h0);
    check("reset_an_err", 32'(u_if.an_err), 32'h0);
    check("reset_err_idx", 32'(u_if.err_idx), 32'h0);
    rst = 1'b0;

    // Plain scan 3..0 showing 1,2,3,4.
    show(3, 1, 10); show(2, 2, 10); show(1, 3, 10); show(0, 4, 10);
    idle(4);
    // Short dwell on digit 2 must not complete the frame.
    show(3, 5, 8); show(2, 6, 3); show(1, 7, 8); show(0, 8, 8);
    idle(6);
    show(2, 6, 4);
    idle(4);
    // Blank pattern on digit 1.
    hold(4'b1101, 7'h7F, 1'b1, 8);
    // Two anodes low, then a normal scan.
    hold(4'b1001, tbl[3], 1'b1, 8);
    show(0, 0, 6); show(1, 1, 6); show(2, 2, 6); show(3, 3, 6);
    idle(4);
    // Same digit twice in one frame: latest wins.
    show(0, 5, 6); show(0, 9, 6); show(1, 15, 6); show(2, 15, 6); show(3, 15, 6);
    idle(4);
    // Reset mid-frame, then a fresh scan.
    show(3, 10, 6); show(2, 11, 6);
    do_reset();
    show(3, 10, 6); show(2, 11, 6); show(1, 12, 6); show(0, 13, 6);
    idle(4);

    // Randomized scans with noise dwells.
    for (int fr = 0; fr < 30; fr++) begin
      for (int i = 0; i < 4; i++) ord[i] = i;
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0: hold(4'($urandom), 7'($urandom), 1'($urandom), $urandom_range(1, 6));
          1: show(ord[i], $urandom_range(0, 15), $urandom_range(1, 3), 1'($urandom));
          default: ;
        endcase
        show(ord[i], $urandom_range(0, 15), $urandom_range(4, 9), 1'($urandom));
      end
    end
    idle(8);

    check("frames_drained", 32'(fq.size()), 32'h0);
    check("pat_errs_drained", 32'(pq.size()), 32'h0);
    check("an_errs_drained", 32'(aq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Receive-side monitor for the multiplexed four-digit seven-segment display bus: watches the active-low anode and segment lines and reconstructs the hex value being shown.
- Performs the inverse of the hex-to-segment decode: segment pattern to 4-bit nibble.
- Used for on-board self-check of the display path and as a bench-side checker.
- Captures each digit once it has been stable long enough, then publishes a full frame once every digit has been captured.

Parameters:
- DIGITS, 4, number of multiplexed digits / anode lines.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  DIGITS  anode enables, active-low; an[i]=0 selects digit i (digit 0 = least-significant nibble).
- seg  input  7  segment lines {a,b,c,d,e,f,g}, active-low.
- value  output  4*DIGITS  last complete frame, digit i at bits [4i+3:4i].
- frame_valid  output  1  one-cycle pulse when value updates.
- pat_err  output  1  one-cycle pulse: stable pattern not in decode table.
- an_err  output  1  one-cycle pulse: stable anode word with more than one bit low.
- err_idx  output  clog2(DIGITS)  digit index of the most recent pat_err; holds its value until the next pat_err.

Behaviour:
- Reset: value=0, frame_valid=0, pat_err=0, an_err=0, err_idx=0, shadow=0, seen mask=0, stability counter=0, sample regs=all ones, captured flag=0.
- Sampling: each edge registers {an,seg} into s_an/s_seg.
- Stability counter:
  - Cleared when the current {an,seg} differs from {s_an,s_seg}.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture event: counter reaches STABLE_CYCLES-1 while the inputs still match, i.e. a pattern held for STABLE_CYCLES edges is captured on the STABLE_CYCLES-th edge.
  - captured flag blocks re-capture until the inputs change. Exactly one capture per dwell, however long the dwell.
- On a capture event, classify the anode word:
  - All ones: idle. No action.
  - Exactly one bit low: decode seg.
  - More than one bit low: pulse an_err. No shadow or mask change.
- Decode table (seg to nibble):
  - 0000001 to 0, 1001111 to 1, 0010010 to 2, 0000110 to 3
  - 1001100 to 4, 0100100 to 5, 0100000 to 6, 0001111 to 7
  - 0000000 to 8, 0001100 to 9, 0001000 to A, 1100000 to B
  - 0110001 to C, 1000010 to D, 0110000 to E, 0111000 to F
  - Any other pattern, including all-ones (blank), is invalid.
- Valid decode: write the nibble to shadow slot i and set seen[i]. A repeat of digit i within the same frame overwrites the slot; latest wins.
- Invalid decode: pulse pat_err and set err_idx=i. Shadow and seen are unchanged.
- Frame completion: when seen becomes all ones, on the next edge value<=shadow, frame_valid pulses for 1 cycle, and seen clears. The following capture may occur on that same edge; it sets its own seen bit, and frame clearing must not lose it.
- Latency: the last digit settling produces frame_valid STABLE_CYCLES+1 edges after that digit's pattern first appears.
- Digits may arrive in any order. There is no scan-order check.
- Reset asserted mid-frame discards the partial frame immediately (async). value returns to 0.

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- Defined:
  - Adds input dp (1 bit, active-low decimal point) and output value_dp (DIGITS bits).
  - dp participates in the stability comparison.
  - dp is captured per digit alongside the nibble: value_dp[i]=1 when the point is lit.
  - value_dp publishes with value on frame_valid and resets to 0.
- Undefined: dp and value_dp ports are absent and logic is unchanged.

Test Plan:
- Digits 3,2,1,0 driven with patterns for 1,2,3,4, each held 10 cycles -> value=0x1234 with a single frame_valid pulse 5 edges after digit 0 appears.
- Digit 2 held only 3 cycles (STABLE_CYCLES=4), then the other digits complete -> no frame_valid until digit 2 is held at least 4 cycles; value unchanged before then.
- an=1101 with seg=1111111 held 8 cycles -> pat_err single pulse, err_idx=1, seen[1] stays 0.
- an=1001 with a valid pattern held 8 cycles -> an_err single pulse, no shadow change; a normal scan afterwards yields the correct frame.
- Digit 0 shows 5, then 9 within the same frame, then digits 1-3 show F -> value=0xFFF9.
- rst pulsed after 2 digits captured, then a full scan of A,B,C,D -> value=0 right after reset, then 0xABCD with exactly one frame_valid.
